result_packer: RTL and testbench
================================

Name: result_packer

Overview:
- Downstream neighbour of the core/accumulator datapath.
- Takes the 32-bit result words produced serially by the core and packs pairs of words into 64-bit AXI Stream beats.
- Buffers the beats in a small FIFO and drives the M_AXIS master interface toward the DMA, with TLAST at job end.
- Decouples core result timing from M_AXIS_TREADY backpressure and flags dropped words.

Parameters:
- DEPTH, 16, FIFO depth in 64-bit beats; power of two, minimum 2.
- AW, 4, FIFO pointer width; must equal log2(DEPTH).

Ports:
- AXIS_ACLK  in  1  single clock for the whole block.
- AXIS_ARESETN  in  1  synchronous, active-low reset.
- run  in  1  job enable; low synchronously flushes the block.
- res_v  in  1  result word valid.
- res_d  in  32  result word.
- res_last  in  1  qualifies res_v; marks the final word of the job.
- res_ready  out  1  block can accept a word this cycle.
- M_AXIS_TVALID  out  1  output beat valid.
- M_AXIS_TDATA  out  64  output beat; the earlier word sits in [31:0].
- M_AXIS_TSTRB  out  8  8'hff for a full beat, 8'h0f for a half beat.
- M_AXIS_TLAST  out  1  final beat of the job.
- M_AXIS_TREADY  in  1  downstream ready.
- overflow  out  1  sticky: a word was offered while res_ready was low.
- beat_cnt  out  16  count of completed output handshakes.

Behaviour:
- Clock and reset: one clock, AXIS_ACLK. Reset is synchronous and active-low on AXIS_ARESETN.
- Reset values: all outputs 0, FIFO empty, half flag 0, lo register 0.
- Flush: run==0 has the same effect as reset on every state and output, including overflow and beat_cnt. Flush takes priority over any push or pop in the same cycle.
- Word acceptance: a word is accepted when run & res_v & res_ready.
- res_ready rule: res_ready = run & (count < DEPTH).
  - Depends only on registered state, never on TREADY.
  - A pop in the same cycle does not raise res_ready.
- Packing state machine, two states:
  - EVEN (half=0): an accepted word without res_last goes into lo; next state ODD.
  - EVEN (half=0): an accepted word with res_last pushes {32'h0, res_d}, STRB 8'h0f, LAST 1; state stays EVEN.
  - ODD (half=1): an accepted word pushes {res_d, lo}, STRB 8'hff, LAST = res_last; next state EVEN.
- FIFO entry: each entry stores 64 data bits, 8 strobe bits and 1 last bit.
- FIFO output path:
  - TVALID = (count != 0).
  - TDATA, TSTRB and TLAST are read combinationally from the entry at rd_ptr.
- Latency: a push at edge k makes the beat visible on M_AXIS right after edge k, provided the FIFO was empty.
- Pop: occurs when TVALID & TREADY. rd_ptr increments and beat_cnt increments.
- Pointer and counter wrap:
  - Pointers wrap modulo DEPTH.
  - beat_cnt wraps from 16'hffff to 0.
- Simultaneous push and pop: count unchanged, and both pointers advance.
- Overflow: run & res_v & ~res_ready sets overflow on the next edge. The word is dropped and the packing state is unchanged.
- AXIS stability: while TVALID & ~TREADY, the output beat must not change. A push never alters the head entry.
- No new job start is required: after a TLAST beat the packer is already in EVEN and continues with the next job's words.

Test Plan:
- Reset/flush: hold AXIS_ARESETN=0 for 2 cycles, then release with run=0 -> all outputs 0 and res_ready=0.
- Even job: run=1, TREADY=1, words 0x11111111, 0x22222222, 0x33333333, 0x44444444 with res_last on the 4th ->
  - beat 0x22222222_11111111, STRB ff, TLAST 0;
  - then beat 0x44444444_33333333, STRB ff, TLAST 1;
  - beat_cnt=2.
- Odd job: words 0xA, 0xB, 0xC with res_last on 0xC ->
  - beat 0x0000000B_0000000A, STRB ff, TLAST 0;
  - then beat 0x00000000_0000000C, STRB 0f, TLAST 1.
- Backpressure/overflow: TREADY=0, offer 33 consecutive words with res_v=1 ->
  - res_ready falls after the 32nd word (16 beats);
  - the 33rd word sets overflow=1 and is dropped;
  - with TREADY=1 the bench then receives 16 beats in order, with TVALID stable throughout the stall.
- Mid-job flush: 3 beats queued and one half word held, then drop run for 1 cycle ->
  - next cycle TVALID=0 and overflow=0;
  - after run=1, words 0x5, 0x6 produce beat 0x00000006_00000005.
- Full with simultaneous push/pop: FIFO at count 15, push and pop in the same cycle -> count stays 15 and order is preserved through pointer wrap at 16.

Source files
------------

// File: rtl/result_packer.sv
// Packs serial 32-bit result words into 64-bit AXI Stream beats through a small
// FIFO; the earlier word of each pair lands in the low half of the beat.
module result_packer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        AXIS_ACLK,
    input  logic        AXIS_ARESETN,
    input  logic        run,
    input  logic        res_v,
    input  logic [31:0] res_d,
    input  logic        res_last,
    output logic        res_ready,
    output logic        M_AXIS_TVALID,
    output logic [63:0] M_AXIS_TDATA,
    output logic [7:0]  M_AXIS_TSTRB,
    output logic        M_AXIS_TLAST,
    input  logic        M_AXIS_TREADY,
    output logic        overflow,
    output logic [15:0] beat_cnt
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } half_t;

    half_t          state_reg, state_next;
    logic [31:0]    lo_reg, lo_next;
    logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]    count_reg;
    logic           overflow_reg;
    logic [15:0]    beat_cnt_reg;

    // Entry layout: [72] last, [71:64] strobe, [63:0] data.
    logic [72:0]    mem [DEPTH];
    logic [72:0]    head_entry;
    logic [72:0]    push_entry;
    logic           accept, push, pop;

    assign res_ready     = run & (count_reg < DEPTH_C);
    assign accept        = res_v & res_ready;
    assign M_AXIS_TVALID = (count_reg != '0);
    assign pop           = M_AXIS_TVALID & M_AXIS_TREADY;

    // Head is read combinationally so a beat pushed into an empty FIFO shows
    // on the bus right after the push edge; outputs read 0 while empty.
    assign head_entry    = mem[rd_ptr_reg];
    assign M_AXIS_TDATA  = M_AXIS_TVALID ? head_entry[63:0]  : 64'h0;
    assign M_AXIS_TSTRB  = M_AXIS_TVALID ? head_entry[71:64] : 8'h00;
    assign M_AXIS_TLAST  = M_AXIS_TVALID ? head_entry[72]    : 1'b0;
    assign overflow      = overflow_reg;
    assign beat_cnt      = beat_cnt_reg;

    always_comb begin
        state_next = state_reg;
        lo_next    = lo_reg;
        push       = 1'b0;
        push_entry = '0;
        if (accept) begin
            if (state_reg == EVEN) begin
                if (res_last) begin
                    push       = 1'b1;
                    push_entry = {1'b1, 8'h0f, 32'h0, res_d};
                end else begin
                    lo_next    = res_d;
                    state_next = ODD;
                end
            end else begin
                push       = 1'b1;
                push_entry = {res_last, 8'hff, res_d, lo_reg};
                state_next = EVEN;
            end
        end
    end

    // Dropping run clears everything exactly like reset and beats any push/pop.
    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN || !run) begin
            state_reg    <= EVEN;
            lo_reg       <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            lo_reg    <= lo_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg   <= rd_ptr_reg + AW'(1);
                beat_cnt_reg <= beat_cnt_reg + 16'd1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + (AW+1)'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - (AW+1)'(1);
            end
            if (res_v && !res_ready) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

endmodule

// File: tb/tb_result_packer.sv
// Self-checking bench for result_packer: directed jobs plus a randomized run
// against a queue-based model of the packing and FIFO rules.
module tb_result_packer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef logic [72:0] beat_t;   // {last, strb, data}

    logic        clk;
    logic        arstn;
    logic        run;
    logic        res_v;
    logic [31:0] res_d;
    logic        res_last;
    logic        res_ready;
    logic        tvalid;
    logic [63:0] tdata;
    logic [7:0]  tstrb;
    logic        tlast;
    logic        tready;
    logic        overflow;
    logic [15:0] beat_cnt;

    int checks;
    int errors;

    // Model state
    beat_t       mq[$];
    beat_t       exp_out[$];
    beat_t       got[$];
    bit          m_half;
    logic [31:0] m_lo;
    bit          m_ovf;
    logic [15:0] m_bcnt;

    result_packer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESETN  (arstn),
        .run           (run),
        .res_v         (res_v),
        .res_d         (res_d),
        .res_last      (res_last),
        .res_ready     (res_ready),
        .M_AXIS_TVALID (tvalid),
        .M_AXIS_TDATA  (tdata),
        .M_AXIS_TSTRB  (tstrb),
        .M_AXIS_TLAST  (tlast),
        .M_AXIS_TREADY (tready),
        .overflow      (overflow),
        .beat_cnt      (beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every completed handshake, sampled mid-cycle.
    always @(negedge clk) begin
        if (arstn && run && tvalid && tready)
            got.push_back({tlast, tstrb, tdata});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic drive(input bit r, input bit v, input logic [31:0] d,
                         input bit l, input bit tr);
        run = r; res_v = v; res_d = d; res_last = l; tready = tr;
        #1;
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        bit flush, do_pop, do_acc;
        flush  = !arstn || !run;
        do_pop = (mq.size() != 0) && tready;
        do_acc = res_v && (mq.size() < DEPTH);
        @(posedge clk);
        if (flush) begin
            mq.delete();
            m_half = 0; m_lo = '0; m_ovf = 0; m_bcnt = '0;
        end else begin
            if (res_v && !do_acc) m_ovf = 1;
            if (do_pop) begin
                exp_out.push_back(mq.pop_front());
                m_bcnt = m_bcnt + 16'd1;
            end
            if (do_acc) begin
                if (m_half) begin
                    mq.push_back({res_last, 8'hff, res_d, m_lo});
                    m_half = 0;
                end else if (res_last) begin
                    mq.push_back({1'b1, 8'h0f, 32'h0, res_d});
                end else begin
                    m_lo = res_d;
                    m_half = 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        arstn = 0;
        drive(0, 0, '0, 0, 0);
        tick(); tick();
        arstn = 1;
        drive(0, 0, '0, 0, 0);
        tick();
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL reset_res_ready got %0b exp 0", res_ready); end
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %0b exp 0", tvalid); end
        checks++; if ({tlast, tstrb, tdata} !== 73'h0) begin errors++; $display("FAIL reset_beat got %h exp 0", {tlast, tstrb, tdata}); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
        checks++; if (beat_cnt !== 16'h0) begin errors++; $display("FAIL reset_beat_cnt got %0d exp 0", beat_cnt); end
    endtask

    task automatic test_even_job();
        logic [31:0] w[4];
        beat_t e0, e1;
        w[0] = 32'h11111111; w[1] = 32'h22222222; w[2] = 32'h33333333; w[3] = 32'h44444444;
        e0 = {1'b0, 8'hff, 64'h22222222_11111111};
        e1 = {1'b1, 8'hff, 64'h44444444_33333333};
        got.delete(); exp_out.delete();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, w[i], i == 3, 1);
            tick();
            if (i == 1) begin
                checks++; if (tvalid !== 1'b1) begin errors++; $display("FAIL even_latency tvalid got %0b exp 1", tvalid); end
            end
        end
        for (int i = 0; i < 3; i++) begin drive(1, 0, '0, 0, 1); tick(); end
        checks++;
        if (got.size() != 2) begin errors++; $display("FAIL even_count got %0d exp 2", got.size()); end
        else begin
            checks++; if (got[0] !== e0) begin errors++; $display("FAIL even_beat0 got %h exp %h", got[0], e0); end
            checks++; if (got[1] !== e1) begin errors++; $display("FAIL even_beat1 got %h exp %h", got[1], e1); end
        end
        checks++; if (beat_cnt !== 16'd2) begin errors++; $display("FAIL even_beat_cnt got %0d exp 2", beat_cnt); end
    endtask

    task automatic test_odd_job();
        beat_t e0, e1;
        e0 = {1'b0, 8'hff, 64'h0000000B_0000000A};
        e1 = {1'b1, 8'h0f, 64'h00000000_0000000C};
        got.delete(); exp_out.delete();
        drive(1, 1, 32'hA, 0, 1); tick();
        drive(1, 1, 32'hB, 0, 1); tick();
        drive(1, 1, 32'hC, 1, 1); tick();
        for (int i = 0; i < 3; i++) begin drive(1, 0, '0, 0, 1); tick(); end
        checks++;
        if (got.size() != 2) begin errors++; $display("FAIL odd_count got %0d exp 2", got.size()); end
        else begin
            checks++; if (got[0] !== e0) begin errors++; $display("FAIL odd_beat0 got %h exp %h", got[0], e0); end
            checks++; if (got[1] !== e1) begin errors++; $display("FAIL odd_beat1 got %h exp %h", got[1], e1); end
        end
        checks++; if (beat_cnt !== 16'd4) begin errors++; $display("FAIL odd_beat_cnt got %0d exp 4", beat_cnt); end
    endtask

    task automatic test_backpressure();
        beat_t hold;
        got.delete(); exp_out.delete();
        hold = '0;
        for (int i = 0; i < 33; i++) begin
            drive(1, 1, $urandom, 0, 0);
            checks++;
            if (res_ready !== (i < 32)) begin errors++; $display("FAIL bp_res_ready word %0d got %0b exp %0b", i, res_ready, (i < 32)); end
            if (i == 2) hold = {tlast, tstrb, tdata};
            if (i > 2) begin
                checks++;
                if (!tvalid || {tlast, tstrb, tdata} !== hold) begin
                    errors++; $display("FAIL bp_stable word %0d got %b/%h exp 1/%h", i, tvalid, {tlast, tstrb, tdata}, hold);
                end
            end
            tick();
        end
        drive(1, 0, '0, 0, 0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got %0b exp 1", overflow); end
        for (int i = 0; i < 18; i++) begin drive(1, 0, '0, 0, 1); tick(); end
        checks++; if (got.size() != 16) begin errors++; $display("FAIL bp_count got %0d exp 16", got.size()); end
        for (int i = 0; i < got.size() && i < exp_out.size(); i++) begin
            checks++; if (got[i] !== exp_out[i]) begin errors++; $display("FAIL bp_beat%0d got %h exp %h", i, got[i], exp_out[i]); end
        end
        checks++; if (beat_cnt !== m_bcnt) begin errors++; $display("FAIL bp_beat_cnt got %0d exp %0d", beat_cnt, m_bcnt); end
    endtask

    task automatic test_mid_flush();
        beat_t e0;
        e0 = {1'b0, 8'hff, 64'h00000006_00000005};
        got.delete(); exp_out.delete();
        for (int i = 0; i < 7; i++) begin drive(1, 1, $urandom, 0, 0); tick(); end
        drive(0, 0, '0, 0, 0); tick();
        drive(1, 0, '0, 0, 0);
        checks++; if (tvalid !== 1'b0) begin errors++; $display("FAIL flush_tvalid got %0b exp 0", tvalid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL flush_overflow got %0b exp 0", overflow); end
        checks++; if (beat_cnt !== 16'h0) begin errors++; $display("FAIL flush_beat_cnt got %0d exp 0", beat_cnt); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL flush_res_ready got %0b exp 1", res_ready); end
        drive(1, 1, 32'h5, 0, 0); tick();
        drive(1, 1, 32'h6, 0, 0); tick();
        drive(1, 0, '0, 0, 0);
        checks++;
        if (!tvalid || {tlast, tstrb, tdata} !== e0) begin
            errors++; $display("FAIL flush_beat got %b/%h exp 1/%h", tvalid, {tlast, tstrb, tdata}, e0);
        end
        for (int i = 0; i < 3; i++) begin drive(1, 0, '0, 0, 1); tick(); end
        checks++; if (got.size() != 1) begin errors++; $display("FAIL flush_count got %0d exp 1", got.size()); end
    endtask

    task automatic test_full_push_pop();
        got.delete(); exp_out.delete();
        for (int i = 0; i < 31; i++) begin drive(1, 1, $urandom, 0, 0); tick(); end
        drive(1, 1, $urandom, 0, 1);
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL full15_res_ready got %0b exp 1", res_ready); end
        tick();
        drive(1, 0, '0, 0, 0);
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL pushpop_res_ready got %0b exp 1", res_ready); end
        drive(1, 1, $urandom, 0, 0); tick();
        drive(1, 1, $urandom, 0, 0); tick();
        drive(1, 0, '0, 0, 0);
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL full16_res_ready got %0b exp 0", res_ready); end
        for (int i = 0; i < 20; i++) begin drive(1, 0, '0, 0, 1); tick(); end
        checks++; if (got.size() != 17) begin errors++; $display("FAIL wrap_count got %0d exp 17", got.size()); end
        for (int i = 0; i < got.size() && i < exp_out.size(); i++) begin
            checks++; if (got[i] !== exp_out[i]) begin errors++; $display("FAIL wrap_beat%0d got %h exp %h", i, got[i], exp_out[i]); end
        end
    endtask

    task automatic test_random();
        bit exp_ready;
        got.delete(); exp_out.delete();
        for (int c = 0; c < 400; c++) begin
            arstn = ($urandom_range(0, 63) != 0);
            drive($urandom_range(0, 31) != 0, $urandom_range(0, 2) != 0, $urandom,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
            exp_ready = run && (mq.size() < DEPTH);
            checks++; if (res_ready !== exp_ready) begin errors++; $display("FAIL rnd_res_ready cyc %0d got %0b exp %0b", c, res_ready, exp_ready); end
            checks++; if (tvalid !== (mq.size() != 0)) begin errors++; $display("FAIL rnd_tvalid cyc %0d got %0b exp %0b", c, tvalid, mq.size() != 0); end
            if (mq.size() != 0) begin
                checks++; if ({tlast, tstrb, tdata} !== mq[0]) begin errors++; $display("FAIL rnd_head cyc %0d got %h exp %h", c, {tlast, tstrb, tdata}, mq[0]); end
            end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow cyc %0d got %0b exp %0b", c, overflow, m_ovf); end
            checks++; if (beat_cnt !== m_bcnt) begin errors++; $display("FAIL rnd_beat_cnt cyc %0d got %0d exp %0d", c, beat_cnt, m_bcnt); end
            tick();
        end
        arstn = 1;
        for (int i = 0; i < 20; i++) begin drive(1, 0, '0, 0, 1); tick(); end
        checks++; if (got.size() != exp_out.size()) begin errors++; $display("FAIL rnd_count got %0d exp %0d", got.size(), exp_out.size()); end
        for (int i = 0; i < got.size() && i < exp_out.size(); i++) begin
            checks++; if (got[i] !== exp_out[i]) begin errors++; $display("FAIL rnd_beat%0d got %h exp %h", i, got[i], exp_out[i]); end
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        m_half = 0; m_lo = '0; m_ovf = 0; m_bcnt = '0;
        arstn = 0; run = 0; res_v = 0; res_d = '0; res_last = 0; tready = 0;
        test_reset();
        test_even_job();
        test_odd_job();
        test_backpressure();
        test_mid_flush();
        test_full_push_pop();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
